input_port_ctrl: RTL and testbench

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

---
 rtl/noc_pkg.sv | 33 +++
 rtl/xy_route.sv | 31 +++
 rtl/input_port_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_input_port_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, route bit positions, port FSM states.
package noc_pkg;

    localparam int ROUTE_W  = 5;
    localparam int RT_LOCAL = 0;
    localparam int RT_N     = 1;
    localparam int RT_E     = 2;
    localparam int RT_S     = 3;
    localparam int RT_W     = 4;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } port_state_e;

    // Flit opens a packet and carries destination coordinates.
    function automatic logic starts_packet(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    // Flit closes a packet.
    function automatic logic ends_packet(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/xy_route.sv
// Dimension-ordered (X first, then Y) route computation to a one-hot port vector.
module xy_route import noc_pkg::*; #(
    parameter int COORD_WIDTH = 2,
    parameter int X_ID        = 0,
    parameter int Y_ID        = 0
) (
    input  logic [COORD_WIDTH-1:0] dst_x,
    input  logic [COORD_WIDTH-1:0] dst_y,
    output logic [ROUTE_W-1:0]     route
);

    localparam logic [COORD_WIDTH-1:0] X_C = X_ID[COORD_WIDTH-1:0];
    localparam logic [COORD_WIDTH-1:0] Y_C = Y_ID[COORD_WIDTH-1:0];

    // Resolve X offset first; only an aligned X lets Y decide.
    always_comb begin
        route = {ROUTE_W{1'b0}};
        if (dst_x > X_C) begin
            route[RT_E] = 1'b1;
        end else if (dst_x < X_C) begin
            route[RT_W] = 1'b1;
        end else if (dst_y > Y_C) begin
            route[RT_N] = 1'b1;
        end else if (dst_y < Y_C) begin
            route[RT_S] = 1'b1;
        end else begin
            route[RT_LOCAL] = 1'b1;
        end
    end

endmodule

// File: rtl/input_port_ctrl.sv
// Router input port: pulls flits from an upstream FIFO into a 2-entry buffer,
// filters protocol errors and presents flits with their XY route to the crossbar.
// Optional macro INPUT_PORT_PKT_CNT_EN adds a 16-bit delivered-packet counter.
module input_port_ctrl import noc_pkg::*; #(
    parameter int DATA_WIDTH  = 8,
    parameter int COORD_WIDTH = 2,
    parameter int X_ID        = 0,
    parameter int Y_ID        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] flit_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [ROUTE_W-1:0]    route_o,
`ifdef INPUT_PORT_PKT_CNT_EN
    output logic [15:0]           pkt_cnt_o,
`endif
    output logic                  err_o
);

    // Registered state
    logic                  run_r;
    logic                  rd_pend_r;
    logic [1:0]            cnt_r;
    logic [DATA_WIDTH-1:0] buf_data_r  [2];
    logic [ROUTE_W-1:0]    buf_route_r [2];
    port_state_e           state_r;
    port_state_e           shadow_r;
    logic [ROUTE_W-1:0]    route_lat_r;
    logic [ROUTE_W-1:0]    route_out_r;
    logic                  valid_r;
    logic                  err_r;

    // Next-state / combinational signals
    logic                  pop_s;
    logic [1:0]            occ_s;
    logic                  rd_en_s;
    flit_type_e            cap_type_s;
    flit_type_e            head_type_s;
    flit_type_e            new_head_type_s;
    logic [ROUTE_W-1:0]    cap_route_s;
    logic                  cap_keep_s;
    logic                  cap_err_s;
    port_state_e           shadow_s;
    logic [1:0]            cnt_v_s;
    logic [1:0]            cnt_s;
    logic [DATA_WIDTH-1:0] buf_data_s  [2];
    logic [ROUTE_W-1:0]    buf_route_s [2];
    port_state_e           state_s;
    logic [ROUTE_W-1:0]    route_lat_s;
    logic [ROUTE_W-1:0]    route_out_s;

    // Route is computed on the incoming read data so each buffered head carries it.
    xy_route #(
        .COORD_WIDTH (COORD_WIDTH),
        .X_ID        (X_ID),
        .Y_ID        (Y_ID)
    ) u_xy_route (
        .dst_x (fifo_data_i[2*COORD_WIDTH-1:COORD_WIDTH]),
        .dst_y (fifo_data_i[COORD_WIDTH-1:0]),
        .route (cap_route_s)
    );

    // Read strobe: space left after counting held entries, the read in flight and this cycle's pop.
    always_comb begin
        pop_s   = (cnt_r != 2'd0) && ready_i;
        occ_s   = cnt_r + {1'b0, rd_pend_r} - {1'b0, pop_s};
        rd_en_s = run_r && !fifo_empty_i && (occ_s < 2'd2);
    end

    // Capture-side packet tracker: drops stray BODY/TAIL and flags misplaced heads.
    always_comb begin
        cap_type_s = flit_type_e'(fifo_data_i[DATA_WIDTH-1:DATA_WIDTH-2]);
        cap_keep_s = 1'b0;
        cap_err_s  = 1'b0;
        shadow_s   = shadow_r;
        if (rd_pend_r) begin
            case (shadow_r)
                ST_IDLE: begin
                    case (cap_type_s)
                        FLIT_HEAD:   begin cap_keep_s = 1'b1; shadow_s = ST_PACKET; end
                        FLIT_SINGLE: begin cap_keep_s = 1'b1; end
                        default:     begin cap_err_s  = 1'b1; end
                    endcase
                end
                ST_PACKET: begin
                    cap_keep_s = 1'b1;
                    case (cap_type_s)
                        FLIT_HEAD:   begin cap_err_s = 1'b1; end
                        FLIT_SINGLE: begin cap_err_s = 1'b1; shadow_s = ST_IDLE; end
                        FLIT_TAIL:   begin shadow_s  = ST_IDLE; end
                        default:     begin shadow_s  = ST_PACKET; end
                    endcase
                end
                default: begin
                    shadow_s = ST_IDLE;
                end
            endcase
        end else begin
            shadow_s = shadow_r;
        end
    end

    // Buffer update: pop shifts entry 1 forward, kept capture appends behind the survivors.
    always_comb begin
        buf_data_s[0]  = buf_data_r[0];
        buf_data_s[1]  = buf_data_r[1];
        buf_route_s[0] = buf_route_r[0];
        buf_route_s[1] = buf_route_r[1];
        if (pop_s) begin
            buf_data_s[0]  = buf_data_r[1];
            buf_route_s[0] = buf_route_r[1];
            cnt_v_s        = cnt_r - 2'd1;
        end else begin
            cnt_v_s = cnt_r;
        end
        if (cap_keep_s) begin
            case (cnt_v_s)
                2'd0: begin
                    buf_data_s[0]  = fifo_data_i;
                    buf_route_s[0] = cap_route_s;
                end
                default: begin
                    buf_data_s[1]  = fifo_data_i;
                    buf_route_s[1] = cap_route_s;
                end
            endcase
            cnt_s = cnt_v_s + 2'd1;
        end else begin
            cnt_s = cnt_v_s;
        end
    end

    // Output FSM and route selection for the flit that will sit at the head next cycle.
    always_comb begin
        head_type_s     = flit_type_e'(buf_data_r[0][DATA_WIDTH-1:DATA_WIDTH-2]);
        new_head_type_s = flit_type_e'(buf_data_s[0][DATA_WIDTH-1:DATA_WIDTH-2]);
        state_s         = state_r;
        route_lat_s     = route_lat_r;
        if (pop_s) begin
            case (head_type_s)
                FLIT_HEAD:   begin state_s = ST_PACKET; route_lat_s = buf_route_r[0]; end
                FLIT_SINGLE: begin state_s = ST_IDLE; end
                FLIT_TAIL:   begin state_s = ST_IDLE; end
                default:     begin state_s = state_r; end
            endcase
        end else begin
            state_s = state_r;
        end
        if ((cnt_s != 2'd0) && starts_packet(new_head_type_s)) begin
            route_out_s = buf_route_s[0];
        end else if (state_s == ST_PACKET) begin
            route_out_s = route_lat_s;
        end else begin
            route_out_s = {ROUTE_W{1'b0}};
        end
    end

    // State registers; reset discards the buffer, the in-flight read and any partial packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_r          <= 1'b0;
            rd_pend_r      <= 1'b0;
            cnt_r          <= 2'd0;
            buf_data_r[0]  <= {DATA_WIDTH{1'b0}};
            buf_data_r[1]  <= {DATA_WIDTH{1'b0}};
            buf_route_r[0] <= {ROUTE_W{1'b0}};
            buf_route_r[1] <= {ROUTE_W{1'b0}};
            state_r        <= ST_IDLE;
            shadow_r       <= ST_IDLE;
            route_lat_r    <= {ROUTE_W{1'b0}};
            route_out_r    <= {ROUTE_W{1'b0}};
            valid_r        <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            run_r          <= 1'b1;
            rd_pend_r      <= rd_en_s;
            cnt_r          <= cnt_s;
            buf_data_r[0]  <= buf_data_s[0];
            buf_data_r[1]  <= buf_data_s[1];
            buf_route_r[0] <= buf_route_s[0];
            buf_route_r[1] <= buf_route_s[1];
            state_r        <= state_s;
            shadow_r       <= shadow_s;
            route_lat_r    <= route_lat_s;
            route_out_r    <= route_out_s;
            valid_r        <= (cnt_s != 2'd0);
            err_r          <= cap_err_s;
        end
    end

`ifdef INPUT_PORT_PKT_CNT_EN
    logic [15:0] pkt_cnt_r;

    // Count packets as their closing flit is accepted; wraps naturally at 16 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_r <= 16'd0;
        end else if (pop_s && ends_packet(head_type_s)) begin
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign pkt_cnt_o = pkt_cnt_r;
`endif

    assign fifo_rd_en_o = rd_en_s;
    assign flit_o       = buf_data_r[0];
    assign valid_o      = valid_r;
    assign route_o      = route_out_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl (X_ID=1, Y_ID=1, 8-bit flits).
// Optional macro INPUT_PORT_PKT_CNT_EN enables the packet-counter checks.
module tb_input_port_ctrl;

    logic       clk_i        = 1'b0;
    logic       rst_ni       = 1'b1;
    logic       fifo_empty_i = 1'b1;
    logic [7:0] fifo_data_i  = 8'h00;
    logic       ready_i      = 1'b0;
    logic       fifo_rd_en_o;
    logic [7:0] flit_o;
    logic       valid_o;
    logic [4:0] route_o;
    logic       err_o;
`ifdef INPUT_PORT_PKT_CNT_EN
    logic [15:0] pkt_cnt_o;
`endif

    input_port_ctrl #(
        .DATA_WIDTH  (8),
        .COORD_WIDTH (2),
        .X_ID        (1),
        .Y_ID        (1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .flit_o       (flit_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .route_o      (route_o),
`ifdef INPUT_PORT_PKT_CNT_EN
        .pkt_cnt_o    (pkt_cnt_o),
`endif
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] flit;
        logic       vis;
        logic [4:0] route;
        logic       err;
    } vec_t;

    vec_t       tbl [15];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q [$];
    logic [7:0] obs_flit [$];
    logic [4:0] obs_route [$];
    logic [7:0] exp_flit [$];
    logic [4:0] exp_route [$];
    int         err_seen;
    int         rd_seen;
    logic       last_valid, last_rd, last_err;
    logic [7:0] last_flit;
    logic [4:0] last_route;
    logic       vtr [24];
    logic [4:0] rtr [24];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] f);
        q.push_back(f);
        fifo_empty_i = 1'b0;
    endtask

    // One clock: sample outputs at the falling edge, then model the FIFO read after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        last_valid = valid_o;
        last_flit  = flit_o;
        last_route = route_o;
        last_err   = err_o;
        last_rd    = fifo_rd_en_o;
        if (last_rd) rd_seen++;
        if (fifo_empty_i) check("rd_while_empty", 16'(last_rd), 16'd0);
        if (last_valid && ready_i) begin
            obs_flit.push_back(last_flit);
            obs_route.push_back(last_route);
        end
        if (last_err) err_seen++;
        @(posedge clk_i);
        #1;
        if (last_rd && q.size() > 0) fifo_data_i = q.pop_front();
        fifo_empty_i = (q.size() == 0);
    endtask

    task automatic clear_obs();
        obs_flit.delete();
        obs_route.delete();
        exp_flit.delete();
        exp_route.delete();
        err_seen = 0;
        rd_seen  = 0;
    endtask

    task automatic do_reset();
        #1;
        rst_ni       = 1'b0;
        ready_i      = 1'b0;
        q.delete();
        fifo_empty_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_obs();
    endtask

    task automatic compare_stream(input string name);
        check({name, "_count"}, 16'(obs_flit.size()), 16'(exp_flit.size()));
        for (int i = 0; i < exp_flit.size(); i++) begin
            if (i < obs_flit.size()) begin
                check({name, "_flit"}, 16'(obs_flit[i]), 16'(exp_flit[i]));
                check({name, "_route"}, 16'(obs_route[i]), 16'(exp_route[i]));
            end
        end
    endtask

    initial begin
        int n_err;
        int first;
        int nvalid;

        tbl[0]  = '{8'hC9, 1'b1, 5'b00100, 1'b0};
        tbl[1]  = '{8'h84, 1'b1, 5'b01000, 1'b0};
        tbl[2]  = '{8'h05, 1'b1, 5'b01000, 1'b0};
        tbl[3]  = '{8'h0A, 1'b1, 5'b01000, 1'b0};
        tbl[4]  = '{8'h4F, 1'b1, 5'b01000, 1'b0};
        tbl[5]  = '{8'h03, 1'b0, 5'b00000, 1'b1};
        tbl[6]  = '{8'h81, 1'b1, 5'b10000, 1'b0};
        tbl[7]  = '{8'h40, 1'b1, 5'b10000, 1'b0};
        tbl[8]  = '{8'hC6, 1'b1, 5'b00010, 1'b0};
        tbl[9]  = '{8'hC5, 1'b1, 5'b00001, 1'b0};
        tbl[10] = '{8'hBF, 1'b1, 5'b00100, 1'b0};
        tbl[11] = '{8'h80, 1'b1, 5'b10000, 1'b1};
        tbl[12] = '{8'h41, 1'b1, 5'b10000, 1'b0};
        tbl[13] = '{8'h42, 1'b0, 5'b00000, 1'b1};
        tbl[14] = '{8'hC4, 1'b1, 5'b01000, 1'b0};

        // Reset state, sampled while reset is held
        #1;
        rst_ni       = 1'b0;
        fifo_empty_i = 1'b0;
        #3;
        check("rst_rd_en", 16'(fifo_rd_en_o), 16'd0);
        check("rst_valid", 16'(valid_o), 16'd0);
        check("rst_flit", 16'(flit_o), 16'd0);
        check("rst_route", 16'(route_o), 16'd0);
        check("rst_err", 16'(err_o), 16'd0);
        do_reset();
        repeat (2) tick();

        // SINGLE to (2,1): one read, valid two cycles later, east route
        ready_i = 1'b1;
        push(8'hC9);
        tick();
        check("single_rd_1", 16'(last_rd), 16'd1);
        tick();
        check("single_rd_2", 16'(last_rd), 16'd0);
        check("single_valid_early", 16'(last_valid), 16'd0);
        tick();
        check("single_valid", 16'(last_valid), 16'd1);
        check("single_flit", 16'(last_flit), 16'hC9);
        check("single_route", 16'(last_route), 16'b00100);
        check("single_err", 16'(last_err), 16'd0);
        tick();
        check("single_valid_after", 16'(last_valid), 16'd0);
        check("single_route_after", 16'(last_route), 16'd0);

        // Table-driven stream: routing in all directions, drops and misplaced heads
        do_reset();
        ready_i = 1'b1;
        n_err = 0;
        foreach (tbl[i]) begin
            push(tbl[i].flit);
            if (tbl[i].vis) begin
                exp_flit.push_back(tbl[i].flit);
                exp_route.push_back(tbl[i].route);
            end
            if (tbl[i].err) n_err++;
        end
        repeat (40) tick();
        compare_stream("table");
        check("table_err_pulses", 16'(err_seen), 16'(n_err));
        check("table_route_idle", 16'(last_route), 16'd0);

        // Four-flit packet at full rate: consecutive valid cycles, constant route
        do_reset();
        ready_i = 1'b1;
        push(8'h84); push(8'h05); push(8'h0A); push(8'h4F);
        for (int i = 0; i < 24; i++) begin
            tick();
            vtr[i] = last_valid;
            rtr[i] = last_route;
        end
        first  = -1;
        nvalid = 0;
        for (int i = 0; i < 24; i++) begin
            if (vtr[i]) begin
                nvalid++;
                if (first < 0) first = i;
            end
        end
        check("burst_valid_count", 16'(nvalid), 16'd4);
        if (first >= 0 && first + 4 < 24) begin
            for (int i = first; i < first + 4; i++) begin
                check("burst_valid_run", 16'(vtr[i]), 16'd1);
                check("burst_route", 16'(rtr[i]), 16'b01000);
            end
            check("burst_route_end", 16'(rtr[first + 4]), 16'd0);
        end else begin
            check("burst_first_valid", 16'(first), 16'd0);
        end

        // Backpressure: at most two reads, head held stable, nothing lost afterwards
        do_reset();
        ready_i = 1'b0;
        push(8'h84); push(8'h05); push(8'h0A); push(8'h4F);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_valid) check("stall_flit_stable", 16'(last_flit), 16'h84);
        end
        check("stall_reads", 16'(rd_seen), 16'd2);
        check("stall_valid", 16'(last_valid), 16'd1);
        check("stall_route", 16'(last_route), 16'b01000);
        ready_i = 1'b1;
        exp_flit  = '{8'h84, 8'h05, 8'h0A, 8'h4F};
        exp_route = '{5'b01000, 5'b01000, 5'b01000, 5'b01000};
        repeat (20) tick();
        compare_stream("stall_drain");

        // Reset after the head is accepted drops the rest of the packet
        do_reset();
        ready_i = 1'b1;
        push(8'h84); push(8'h05);
        for (int i = 0; i < 10 && obs_flit.size() == 0; i++) tick();
        check("mid_head_accepted", 16'(obs_flit.size()), 16'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rd_en", 16'(fifo_rd_en_o), 16'd0);
        check("mid_rst_valid", 16'(valid_o), 16'd0);
        check("mid_rst_flit", 16'(flit_o), 16'd0);
        check("mid_rst_route", 16'(route_o), 16'd0);
        check("mid_rst_err", 16'(err_o), 16'd0);
        q.delete();
        fifo_empty_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_obs();
        ready_i = 1'b1;
        push(8'hC5);
        exp_flit.push_back(8'hC5);
        exp_route.push_back(5'b00001);
        repeat (10) tick();
        compare_stream("post_reset");
        check("post_reset_err", 16'(err_seen), 16'd0);

`ifdef INPUT_PORT_PKT_CNT_EN
        // Packet counter: two multi-flit packets and one SINGLE
        do_reset();
        check("pkt_cnt_reset", pkt_cnt_o, 16'd0);
        ready_i = 1'b1;
        push(8'h84); push(8'h05); push(8'h4F);
        push(8'hC5);
        push(8'h81); push(8'h40);
        repeat (30) tick();
        check("pkt_cnt", pkt_cnt_o, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
